// File: rtl/pusch_scrambler_pkg.sv
// Shared NB-IoT uplink definitions: FSM encoding, Gold-sequence constants
// and the single-step LFSR recurrences used by the PUSCH scrambler.
package pusch_scrambler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int NC_DEFAULT = 1600;
  localparam int LFSR_W     = 31;

  localparam int X1_TAP   = 3;
  localparam int X2_TAP_A = 1;
  localparam int X2_TAP_B = 2;
  localparam int X2_TAP_C = 3;

  localparam logic [LFSR_W-1:0] X1_INIT = 31'd1;

  // Bit i of each register holds x(n+i); one step shifts in x(n+31).
  function automatic logic [LFSR_W-1:0] x1Step(input logic [LFSR_W-1:0] s);
    return {s[X1_TAP] ^ s[0], s[LFSR_W-1:1]};
  endfunction

  function automatic logic [LFSR_W-1:0] x2Step(input logic [LFSR_W-1:0] s);
    return {s[X2_TAP_C] ^ s[X2_TAP_B] ^ s[X2_TAP_A] ^ s[0], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/pusch_scrambler_gold_seq_gen.sv
// Gold-sequence generator: the x1/x2 LFSR pair with load and advance control.
// o_c is the current sequence bit c(n) = x1(n) ^ x2(n) relative to the load point.
module gold_seq_gen
  import pusch_scrambler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_c_init,
  input  logic              i_advance,
  output logic              o_c
);

  logic [LFSR_W-1:0] r_x1;
  logic [LFSR_W-1:0] r_x2;

  // Load wins over advance so a restart always begins from a clean seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (i_load) begin
      r_x1 <= X1_INIT;
      r_x2 <= i_c_init;
    end else if (i_advance) begin
      r_x1 <= x1Step(r_x1);
      r_x2 <= x2Step(r_x2);
    end
  end

  assign o_c = r_x1[0] ^ r_x2[0];

endmodule

// File: rtl/pusch_scrambler.sv
// PUSCH bit scrambler: fast-forwards the Gold generator by NC steps, then
// XORs each accepted input bit with the next sequence bit.
module pusch_scrambler
  import pusch_scrambler_pkg::*;
#(
  parameter int NC = NC_DEFAULT,
  parameter int LW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] c_init,
  input  logic [LW-1:0]     len,
  input  logic              in_en,
  input  logic              d_in,
  output logic              ready,
  output logic              y,
  output logic              out_en,
  output logic              done
);

  localparam int WW = $clog2(NC + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(NC - 1);

  state_t          r_state;
  logic [WW-1:0]   r_warm;
  logic [LW-1:0]   r_cnt;
  logic [LW-1:0]   r_len;
  logic            r_ready;
  logic            r_y;
  logic            r_out_en;
  logic            r_done;

  logic            w_c;
  logic            w_accept;
  logic            w_advance;

  // start has priority over any data bit offered in the same cycle.
  assign w_accept  = (r_state == ST_RUN) && in_en && !start;
  assign w_advance = ((r_state == ST_WARMUP) && !start) || w_accept;

  gold_seq_gen u_gold (
    .clk       (clk),
    .reset     (reset),
    .i_load    (start),
    .i_c_init  (c_init),
    .i_advance (w_advance),
    .o_c       (w_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_warm   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_ready  <= 1'b0;
      r_y      <= 1'b0;
      r_out_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_out_en <= 1'b0;
      r_done   <= 1'b0;
      if (start) begin
        r_state <= ST_WARMUP;
        r_warm  <= '0;
        r_cnt   <= '0;
        r_len   <= len;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ready <= 1'b0;
          end
          ST_WARMUP: begin
            r_warm <= r_warm + WW'(1);
            // An empty codeword finishes right at the end of the fast-forward.
            if (r_warm == WARM_LAST) begin
              if (r_len == '0) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (in_en) begin
              r_y      <= d_in ^ w_c;
              r_out_en <= 1'b1;
              r_cnt    <= r_cnt + LW'(1);
              if (r_cnt == r_len - LW'(1)) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
                r_ready <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready  = r_ready;
  assign y      = r_y;
  assign out_en = r_out_en;
  assign done   = r_done;

endmodule

// File: tb/tb_pusch_scrambler.sv
// Directed-plus-random bench for pusch_scrambler; expected bits come from an
// array-based Gold-sequence model built straight from the x1/x2 recurrences.
module tb_pusch_scrambler;

  localparam int NC = 1600;
  localparam int LW = 16;
  localparam int MAXN = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [30:0]   c_init = '0;
  logic [LW-1:0] len = '0;
  logic          in_en = 1'b0;
  logic          d_in = 1'b0;
  logic          ready;
  logic          y;
  logic          out_en;
  logic          done;

  int checks = 0;
  int failures = 0;

  bit x1Seq [0:NC+MAXN+31];
  bit x2Seq [0:NC+MAXN+31];
  bit cRef  [0:MAXN-1];

  logic [30:0] seedA;
  logic [30:0] seedB;
  int          doneAt;
  int          doneCnt;
  bit          sawReady;
  bit          sawOut;

  pusch_scrambler #(.NC(NC), .LW(LW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .c_init (c_init),
    .len    (len),
    .in_en  (in_en),
    .d_in   (d_in),
    .ready  (ready),
    .y      (y),
    .out_en (out_en),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand both m-sequences from their seeds and take c(n) = x1(n+NC) ^ x2(n+NC).
  task automatic computeGold(input logic [30:0] ci);
    for (int i = 0; i < 31; i++) begin
      x1Seq[i] = (i == 0);
      x2Seq[i] = ci[i];
    end
    for (int m = 31; m <= NC + MAXN + 31; m++) begin
      x1Seq[m] = x1Seq[m-28] ^ x1Seq[m-31];
      x2Seq[m] = x2Seq[m-28] ^ x2Seq[m-29] ^ x2Seq[m-30] ^ x2Seq[m-31];
    end
    for (int n = 0; n < MAXN; n++) cRef[n] = x1Seq[n+NC] ^ x2Seq[n+NC];
  endtask

  task automatic startCodeword(input logic [30:0] ci, input int lenVal, input bit enWith);
    c_init = ci;
    len    = LW'(lenVal);
    start  = 1'b1;
    in_en  = enWith;
    d_in   = 1'b1;
    tick();
    start  = 1'b0;
    in_en  = 1'b0;
    checkOutput("start_out_en", out_en, 0);
  endtask

  // Random in_en during warm-up must be ignored; ready must rise after exactly NC edges.
  task automatic waitWarmup(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    while (!ready && cyc < NC + 20) begin
      in_en = 1'($urandom);
      d_in  = 1'($urandom);
      tick();
      cyc++;
      if (out_en) seen = 1;
    end
    in_en = 1'b0;
    checkOutput({tag, "_warmup_len"}, cyc, NC);
    checkOutput({tag, "_warmup_no_out"}, seen, 0);
  endtask

  // dMode: 0 all zeros, 1 all ones, 2 random.
  task automatic applyStimulus(input string tag, input int nBits, input int lenVal,
                               input bit gapped, input int dMode);
    int k;
    int cyc;
    bit en;
    bit d;
    k   = 0;
    cyc = 0;
    while (k < nBits && cyc < 4 * nBits + 8) begin
      en = gapped ? (cyc % 2 == 0) : 1'b1;
      d  = (dMode == 0) ? 1'b0 : (dMode == 1) ? 1'b1 : 1'($urandom);
      in_en = en;
      d_in  = d;
      tick();
      cyc++;
      checkOutput({tag, "_out_en"}, out_en, en);
      if (en) begin
        checkOutput($sformatf("%s_y%0d", tag, k), y, d ^ cRef[k]);
        checkOutput($sformatf("%s_done%0d", tag, k), done, (k == lenVal - 1));
        k++;
      end else begin
        checkOutput({tag, "_gap_done"}, done, 0);
      end
    end
    in_en = 1'b0;
    if (k < nBits) checkOutput({tag, "_budget"}, k, nBits);
  endtask

  task automatic idleCheck(input string tag);
    in_en = 1'b1;
    d_in  = 1'b1;
    tick();
    in_en = 1'b0;
    checkOutput({tag, "_idle_ready"}, ready, 0);
    checkOutput({tag, "_idle_out_en"}, out_en, 0);
    checkOutput({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_out_en", out_en, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;
    tick();

    $display("[TB] warm-up timing, len=8");
    seedA = 31'($urandom);
    startCodeword(seedA, 8, 0);
    waitWarmup("w8");
    computeGold(seedA);
    applyStimulus("w8", 8, 8, 0, 2);
    idleCheck("w8");

    $display("[TB] zero data, c_init=0, len=64");
    startCodeword(31'd0, 64, 0);
    waitWarmup("z64");
    computeGold(31'd0);
    applyStimulus("z64", 64, 64, 0, 0);
    idleCheck("z64");

    $display("[TB] complemented and plain data, c_init=12345678");
    startCodeword(31'h12345678, 32, 0);
    waitWarmup("ones");
    computeGold(31'h12345678);
    applyStimulus("ones", 32, 32, 0, 1);
    idleCheck("ones");
    startCodeword(31'h12345678, 32, 0);
    waitWarmup("zeros");
    applyStimulus("zeros", 32, 32, 0, 0);
    idleCheck("zeros");

    $display("[TB] gapped input");
    seedA = 31'($urandom);
    startCodeword(seedA, 40, 0);
    waitWarmup("gap");
    computeGold(seedA);
    applyStimulus("gap", 40, 40, 1, 2);
    idleCheck("gap");

    $display("[TB] restart after 10 bits, start with in_en");
    seedA = 31'($urandom);
    seedB = 31'($urandom);
    startCodeword(seedA, 64, 0);
    waitWarmup("rsA");
    computeGold(seedA);
    applyStimulus("rsA", 10, 64, 0, 2);
    startCodeword(seedB, 16, 1);
    waitWarmup("rsB");
    computeGold(seedB);
    applyStimulus("rsB", 16, 16, 0, 2);
    idleCheck("rsB");

    $display("[TB] reset mid-run");
    seedA = 31'($urandom);
    startCodeword(seedA, 64, 0);
    waitWarmup("rr");
    computeGold(seedA);
    applyStimulus("rr", 5, 64, 0, 1);
    in_en = 1'b1;
    d_in  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rr_async_out_en", out_en, 0);
    checkOutput("rr_async_ready", ready, 0);
    checkOutput("rr_async_y", y, 0);
    checkOutput("rr_async_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_en = 1'b1;
      d_in  = 1'($urandom);
      tick();
      checkOutput("rr_after_ready", ready, 0);
      checkOutput("rr_after_out_en", out_en, 0);
    end
    in_en = 1'b0;

    $display("[TB] len=0");
    doneAt   = -1;
    doneCnt  = 0;
    sawReady = 0;
    sawOut   = 0;
    startCodeword(31'($urandom), 0, 0);
    for (int k = 1; k <= NC + 5; k++) begin
      in_en = 1'($urandom);
      d_in  = 1'($urandom);
      tick();
      if (done) begin
        doneAt = k;
        doneCnt++;
      end
      if (ready) sawReady = 1;
      if (out_en) sawOut = 1;
    end
    in_en = 1'b0;
    checkOutput("len0_done_at", doneAt, NC);
    checkOutput("len0_done_count", doneCnt, 1);
    checkOutput("len0_no_ready", sawReady, 0);
    checkOutput("len0_no_out_en", sawOut, 0);

    $display("[TB] len=1");
    seedA = 31'($urandom);
    startCodeword(seedA, 1, 0);
    waitWarmup("l1");
    computeGold(seedA);
    applyStimulus("l1", 1, 1, 0, 2);
    idleCheck("l1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
